dsa_lane_scheduler: RTL and testbench
=====================================

DSA_LANE_SCHEDULER -- requirements
Module: dsa_lane_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, giving the number of parallel interpolation lanes (2..8).
REQ-002 The block SHALL have parameter DIM_W, default 16, giving the output-dimension width in bits.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a frame; honoured only in S_IDLE.
REQ-006 out_width  input  DIM_W  output image width in pixels; sampled on accepted start.
REQ-007 out_height  input  DIM_W  output image height in pixels; sampled on accepted start.
REQ-008 lane_ready  input  NUM_LANES  lane i can accept a pixel job this cycle.
REQ-009 lane_done  input  NUM_LANES  one-cycle pulse: lane i finished its outstanding job.
REQ-010 lane_valid  output  NUM_LANES  one-hot (or zero) job issue strobe to lane i.
REQ-011 dst_x  output  DIM_W  destination column of the issued job; valid when lane_valid != 0.
REQ-012 dst_y  output  DIM_W  destination row of the issued job; valid when lane_valid != 0.
REQ-013 busy  output  1  high in S_DISPATCH and S_DRAIN.
REQ-014 done  output  1  one-cycle pulse when the frame completes.
REQ-015 err  output  1  one-cycle pulse when start is accepted with a zero dimension.

Function
REQ-016 The FSM SHALL use four states: S_IDLE, S_DISPATCH, S_DRAIN, S_DONE.
REQ-017 In S_IDLE with start=1: if out_width=0 or out_height=0, the FSM SHALL go to S_DONE and pulse err; otherwise it SHALL latch the dimensions, clear x/y/counters, and go to S_DISPATCH.
REQ-018 Each lane SHALL have a pending bit; a job is issued to lane i only if lane_ready[i]=1 and pending[i]=0, both sampled as registered or current-cycle values.
REQ-019 At most one lane SHALL be issued per cycle, chosen by round-robin starting at the lane after the last one issued (pointer resets to lane 0).
REQ-020 On issue, pending[i] SHALL set, dst_x/dst_y SHALL carry the current coordinate, and the coordinate SHALL advance in raster order (x+1; at x=width-1, x wraps to 0 and y increments).
REQ-021 lane_done[i] SHALL clear pending[i] and increment the completed count; several lanes completing in the same cycle SHALL all be counted (popcount).
REQ-022 lane_done[i] with pending[i]=0 SHALL be ignored: no count, no state change.
REQ-023 A lane freed by lane_done in cycle N SHALL NOT be re-issued before cycle N+1.
REQ-024 The issued and completed counters SHALL be 2*DIM_W bits wide, and total SHALL equal width*height computed at full width without truncation.
REQ-025 When issued reaches total, the FSM SHALL move S_DISPATCH->S_DRAIN, and lane_valid SHALL stay 0 thereafter.
REQ-026 In S_DRAIN, when completed (including same-cycle completions) reaches total, the FSM SHALL go to S_DONE; S_DONE SHALL last one cycle, assert done, then return to S_IDLE.
REQ-027 start outside S_IDLE SHALL be ignored.
REQ-028 Latency: with start accepted in cycle N and a lane ready, the first lane_valid SHALL occur in cycle N+1.

Reset
REQ-029 While rst=1 the block SHALL enter S_IDLE, clear pending bits, counters, coordinates and the RR pointer, and drive lane_valid=0, dst_x=0, dst_y=0, busy=0, done=0, err=0.
REQ-030 rst asserted mid-frame SHALL abandon the frame; later lane_done pulses SHALL be ignored as non-pending.

Verification
REQ-031 4x2 frame, all lanes always ready, each lane_done 3 cycles after issue -> issue order lanes 0,1,2,3,0,1,2,3; coordinates (0,0)..(3,0),(0,1)..(3,1); a single done pulse after the 8th completion.
REQ-032 width=0, height=5, start -> err and done both pulse one cycle later, busy stays 0, no lane_valid.
REQ-033 Lanes 1 and 3 complete in the same cycle -> completed increases by 2, and both lanes become issuable the next cycle.
REQ-034 lane_ready=0 on lane 0 only -> jobs rotate across lanes 1..3 only, and coordinates stay contiguous.
REQ-035 Spurious lane_done[2] while idle, and start while busy -> no counter change and no restart.
REQ-036 rst after 3 issued jobs of a 16x16 frame -> all outputs go to 0 next cycle; a new start then produces (0,0) first.

Source files
------------

// File: rtl/dsa_lane_scheduler_if.sv
// Job-issue bus between the lane scheduler and its interpolation lanes.
// Member names carry the scheduler's point of view (i_ into it, o_ out of it).
interface dsa_lane_scheduler_if #(
  parameter int NUM_LANES = 4,
  parameter int DIM_W     = 16
);
  logic                 i_start;
  logic [DIM_W-1:0]     i_out_width;
  logic [DIM_W-1:0]     i_out_height;
  logic [NUM_LANES-1:0] i_lane_ready;
  logic [NUM_LANES-1:0] i_lane_done;
  logic [NUM_LANES-1:0] o_lane_valid;
  logic [DIM_W-1:0]     o_dst_x;
  logic [DIM_W-1:0]     o_dst_y;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  modport slave (
    input  i_start, i_out_width, i_out_height, i_lane_ready, i_lane_done,
    output o_lane_valid, o_dst_x, o_dst_y, o_busy, o_done, o_err
  );

  modport master (
    output i_start, i_out_width, i_out_height, i_lane_ready, i_lane_done,
    input  o_lane_valid, o_dst_x, o_dst_y, o_busy, o_done, o_err
  );
endinterface

// File: rtl/dsa_lane_scheduler.sv
// Raster-order pixel job dispatcher feeding NUM_LANES interpolation lanes.
//   state      | meaning
//   S_IDLE     | waiting for start
//   S_DISPATCH | issuing one job per cycle, round-robin over free ready lanes
//   S_DRAIN    | all jobs issued, waiting for outstanding completions
//   S_DONE     | one-cycle done (and err for a zero-sized frame)
module dsa_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int DIM_W     = 16
) (
  input logic                 i_clk,
  input logic                 i_rst,
  dsa_lane_scheduler_if.slave bus
);

  localparam int CNT_W = 2 * DIM_W;
  localparam int PTR_W = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_LANES-1:0] r_pending;
  logic [PTR_W-1:0]     r_rr;
  logic [DIM_W-1:0]     r_x;
  logic [DIM_W-1:0]     r_y;
  logic [DIM_W-1:0]     r_w;
  logic [CNT_W-1:0]     r_total;
  logic [CNT_W-1:0]     r_issued;
  logic [CNT_W-1:0]     r_completed;
  logic                 r_err;

  logic [NUM_LANES-1:0] w_eligible;
  logic [NUM_LANES-1:0] w_done_hits;
  logic [NUM_LANES-1:0] w_grant;
  logic [CNT_W-1:0]     w_done_cnt;
  logic [CNT_W-1:0]     w_completed_sum;
  logic [PTR_W-1:0]     w_pick;
  logic                 w_found;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_zero_dim;
  logic                 w_busy;
  logic                 w_done;

  assign w_accept   = (r_state == S_IDLE) && bus.i_start;
  assign w_zero_dim = (bus.i_out_width == '0) || (bus.i_out_height == '0);

  // Completions only count for lanes that really hold a job; stray pulses drop out here.
  assign w_done_hits     = bus.i_lane_done & r_pending;
  assign w_completed_sum = r_completed + w_done_cnt;

  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_done_cnt = w_done_cnt + CNT_W'(w_done_hits[i]);
    end
  end

  // Registered pending keeps a lane freed this cycle out of the search until next cycle.
  always_comb begin
    w_eligible = bus.i_lane_ready & ~r_pending;
    w_found    = 1'b0;
    w_pick     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!w_found && w_eligible[(int'(r_rr) + i) % NUM_LANES]) begin
        w_found = 1'b1;
        w_pick  = PTR_W'((int'(r_rr) + i) % NUM_LANES);
      end
    end
  end

  assign w_issue = (r_state == S_DISPATCH) && w_found;
  assign w_grant = w_issue ? (NUM_LANES'(1) << w_pick) : '0;

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_next = w_zero_dim ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        w_busy = 1'b1;
        if (w_issue && (r_issued + CNT_W'(1) == r_total)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_completed_sum >= r_total) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_rr        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_w         <= '0;
      r_total     <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pending   <= (r_pending & ~w_done_hits) | w_grant;
      r_completed <= w_completed_sum;
      r_err       <= w_accept && w_zero_dim;
      if (w_accept && !w_zero_dim) begin
        r_w         <= bus.i_out_width;
        r_total     <= CNT_W'(bus.i_out_width) * CNT_W'(bus.i_out_height);
        r_x         <= '0;
        r_y         <= '0;
        r_issued    <= '0;
        r_completed <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + CNT_W'(1);
        r_rr     <= (w_pick == PTR_W'(NUM_LANES - 1)) ? '0 : w_pick + PTR_W'(1);
        if (r_x == r_w - DIM_W'(1)) begin
          r_x <= '0;
          r_y <= r_y + DIM_W'(1);
        end else begin
          r_x <= r_x + DIM_W'(1);
        end
      end
    end
  end

  // Outputs forced quiet for the whole reset cycle, not just after the edge.
  assign bus.o_lane_valid = i_rst ? '0 : w_grant;
  assign bus.o_dst_x      = (i_rst || !w_issue) ? '0 : r_x;
  assign bus.o_dst_y      = (i_rst || !w_issue) ? '0 : r_y;
  assign bus.o_busy       = !i_rst && w_busy;
  assign bus.o_done       = !i_rst && w_done;
  assign bus.o_err        = !i_rst && r_err;

endmodule

// File: tb/tb_dsa_lane_scheduler.sv
// Bench for dsa_lane_scheduler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_dsa_lane_scheduler;
  localparam int N  = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsa_lane_scheduler_if #(.NUM_LANES(N), .DIM_W(DW)) bus ();
  dsa_lane_scheduler #(.NUM_LANES(N), .DIM_W(DW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model: frame phase 0 idle, 1 issuing, 2 draining, 3 finishing
  int       m_phase = 0;
  bit       m_err = 0;
  bit [N-1:0] m_pend = '0;
  int       m_rr = 0;
  int       m_w = 1;
  longint   m_total = 0;
  longint   m_k = 0;
  longint   m_comp = 0;

  // lane environment
  int       tmr[N];
  bit       auto_en = 1;
  int       fixed_delay = 3;
  logic [N-1:0] extra_done = '0;

  // observation log
  int log_lane[$];
  int log_x[$];
  int log_y[$];
  int log_cyc[$];
  int n_done = 0, n_err = 0, n_busy = 0;
  int cyc = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    log_lane.delete(); log_x.delete(); log_y.delete(); log_cyc.delete();
    n_done = 0; n_err = 0; n_busy = 0;
  endtask

  // Compare process: expected outputs from the model, then advance the model.
  always @(negedge clk) begin
    int pick;
    pick = -1;
    if (rst) begin
      chk("rst_lane_valid", bus.o_lane_valid, 0);
      chk("rst_dst_x", bus.o_dst_x, 0);
      chk("rst_dst_y", bus.o_dst_y, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_err", bus.o_err, 0);
      m_phase = 0; m_err = 0; m_pend = '0; m_rr = 0; m_k = 0; m_comp = 0;
    end else begin
      if (m_phase == 1) begin
        for (int i = 0; i < N; i++) begin
          int l;
          l = (m_rr + i) % N;
          if (pick < 0 && bus.i_lane_ready[l] && !m_pend[l]) pick = l;
        end
      end
      chk("lane_valid", bus.o_lane_valid, (pick >= 0) ? (1 << pick) : 0);
      if (pick >= 0) begin
        chk("dst_x", bus.o_dst_x, m_k % m_w);
        chk("dst_y", bus.o_dst_y, m_k / m_w);
      end
      chk("busy", bus.o_busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
      chk("done", bus.o_done, (m_phase == 3) ? 1 : 0);
      chk("err", bus.o_err, (m_phase == 3 && m_err) ? 1 : 0);

      m_comp += $countones(bus.i_lane_done & m_pend);
      m_pend &= ~bus.i_lane_done;
      if (pick >= 0) begin
        m_pend[pick] = 1'b1;
        m_k++;
        m_rr = (pick + 1) % N;
        tmr[pick] = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
      end
      case (m_phase)
        0: if (bus.i_start) begin
             if (bus.i_out_width == 0 || bus.i_out_height == 0) begin
               m_phase = 3; m_err = 1;
             end else begin
               m_phase = 1;
               m_w = int'(bus.i_out_width);
               m_total = longint'(bus.i_out_width) * longint'(bus.i_out_height);
               m_k = 0; m_comp = 0;
             end
           end
        1: if (pick >= 0 && m_k == m_total) m_phase = 2;
        2: if (m_comp >= m_total) m_phase = 3;
        default: begin m_phase = 0; m_err = 0; end
      endcase
    end
    if (bus.o_lane_valid != 0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.o_lane_valid[i]) begin
          log_lane.push_back(i);
          log_x.push_back(int'(bus.o_dst_x));
          log_y.push_back(int'(bus.o_dst_y));
          log_cyc.push_back(cyc);
        end
      end
    end
    n_done += int'(bus.o_done);
    n_err  += int'(bus.o_err);
    n_busy += int'(bus.o_busy);
    cyc++;
  end

  // Advance one clock; lane_done for this cycle comes from job timers plus any forced bits.
  task automatic tick();
    logic [N-1:0] d;
    @(posedge clk);
    #1;
    d = extra_done;
    extra_done = '0;
    if (auto_en) begin
      for (int l = 0; l < N; l++) begin
        if (tmr[l] > 0) begin
          tmr[l]--;
          if (tmr[l] == 0) d[l] = 1'b1;
        end
      end
    end
    bus.i_lane_done = d;
  endtask

  task automatic start_frame(int w, int h);
    bus.i_out_width  = DW'(w);
    bus.i_out_height = DW'(h);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic wait_frame(string name, int budget);
    int n;
    n = 0;
    while (m_phase != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, (n >= budget) ? 1 : 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    longint comp_before;
    int done_cyc;
    int n;
    for (int l = 0; l < N; l++) tmr[l] = 0;
    bus.i_start = 0; bus.i_out_width = 0; bus.i_out_height = 0;
    bus.i_lane_ready = '0; bus.i_lane_done = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_valid", bus.o_lane_valid, 0);
    rst = 1'b0;
    tick();

    // 4x2 frame, all ready, completions 3 cycles after issue
    clear_log();
    bus.i_lane_ready = '1; fixed_delay = 3; auto_en = 1;
    start_frame(4, 2);
    wait_frame("t1", 100);
    chk("t1_issue_count", log_lane.size(), 8);
    for (int i = 0; i < 8 && i < log_lane.size(); i++) begin
      chk("t1_lane", log_lane[i], i % 4);
      chk("t1_x", log_x[i], i % 4);
      chk("t1_y", log_y[i], i / 4);
    end
    if (log_cyc.size() > 0) chk("t1_first_issue_latency", log_cyc[0], 4);
    chk("t1_done_pulses", n_done, 1);
    tick();

    // zero width
    clear_log();
    start_frame(0, 5);
    repeat (3) tick();
    chk("t2_err_pulses", n_err, 1);
    chk("t2_done_pulses", n_done, 1);
    chk("t2_busy_cycles", n_busy, 0);
    chk("t2_issues", log_lane.size(), 0);

    // lane 0 never ready
    clear_log();
    bus.i_lane_ready = 4'b1110;
    start_frame(3, 2);
    wait_frame("t3", 100);
    chk("t3_issue_count", log_lane.size(), 6);
    for (int i = 0; i < 6 && i < log_lane.size(); i++) begin
      chk("t3_lane", log_lane[i], 1 + (i % 3));
      chk("t3_x", log_x[i], i % 3);
      chk("t3_y", log_y[i], i / 3);
    end
    tick();

    // lanes 1 and 3 complete together
    bus.i_lane_ready = '1;
    auto_en = 0;
    start_frame(4, 4);
    repeat (6) tick();
    comp_before = m_comp;
    clear_log();
    extra_done = 4'b1010;
    tmr[1] = 0; tmr[3] = 0;
    tick();
    done_cyc = cyc;
    tick(); tick(); tick();
    chk("t4_completed_delta", m_comp - comp_before, 2);
    chk("t4_issue_count", log_lane.size(), 2);
    if (log_lane.size() >= 2) begin
      chk("t4_lane_a", log_lane[0], 1);
      chk("t4_lane_b", log_lane[1], 3);
      chk("t4_cyc_a", log_cyc[0], done_cyc + 1);
      chk("t4_cyc_b", log_cyc[1], done_cyc + 2);
    end
    auto_en = 1;
    wait_frame("t4", 300);
    tick();

    // spurious completion while idle, start while busy
    clear_log();
    comp_before = m_comp;
    extra_done = 4'b0100;
    tick(); tick();
    chk("t5_idle_comp_delta", m_comp - comp_before, 0);
    chk("t5_idle_busy", n_busy, 0);
    chk("t5_idle_done", n_done, 0);
    start_frame(2, 2);
    tick();
    start_frame(0, 7);
    wait_frame("t5", 100);
    chk("t5_issue_count", log_lane.size(), 4);
    chk("t5_err_pulses", n_err, 0);
    chk("t5_done_pulses", n_done, 1);
    tick();

    // reset mid-frame after three issues
    clear_log();
    start_frame(16, 16);
    n = 0;
    while (log_lane.size() < 3 && n < 50) begin tick(); n++; end
    chk("t6_three_issued", log_lane.size() >= 3 ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    chk("t6_valid_in_rst", bus.o_lane_valid, 0);
    chk("t6_busy_in_rst", bus.o_busy, 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    clear_log();
    start_frame(2, 1);
    wait_frame("t6", 100);
    chk("t6_issue_count", log_lane.size(), 2);
    if (log_lane.size() > 0) begin
      chk("t6_first_lane", log_lane[0], 0);
      chk("t6_first_x", log_x[0], 0);
      chk("t6_first_y", log_y[0], 0);
    end
    tick();

    // randomized frames
    fixed_delay = 0;
    for (int f = 0; f < 60; f++) begin
      int w, h;
      w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      h = int'($urandom_range(1, 5));
      bus.i_lane_ready = N'($urandom);
      start_frame(w, h);
      n = 0;
      while (m_phase != 0 && n < 400) begin
        bus.i_lane_ready = N'($urandom);
        if ($urandom_range(0, 19) == 0) extra_done = N'(1) << $urandom_range(0, N - 1);
        if ($urandom_range(0, 14) == 0) begin
          bus.i_start = 1'b1;
          bus.i_out_width = DW'($urandom_range(0, 3));
        end else begin
          bus.i_start = 1'b0;
        end
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
        n++;
      end
      bus.i_start = 1'b0;
      chk("rand_frame_timeout", (n >= 400) ? 1 : 0, 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (10) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
